// File: rtl/sbox_lane_pipe.sv
// Multi-lane AES S-box with an elastic valid/ready register pipeline.
// Each beat carries LANES independent bytes plus a mode bit (0 = SubBytes,
// 1 = InvSubBytes). The mode bit travels with its beat through every stage.
// The pipeline has PIPE register stages:
//   PIPE=1: lookup -> output register
//   PIPE=2: input register -> lookup -> output register
//   PIPE=3: input register -> lookup -> retiming register -> output register
module sbox_lane_pipe #(
  parameter int LANES  = 16,
  parameter int PIPE   = 2,
  parameter bit INV_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int W = 8 * LANES;

  // Forward table, byte 0x00 in the most significant position.
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The inverse table is the forward table inverted as a permutation, so the
  // two can never disagree.
  function automatic logic [2047:0] build_inv();
    logic [2047:0] r;
    logic [7:0]    iv;
    logic [7:0]    f;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      f  = FWD_TBL[11'd2047 - {iv, 3'b000} -: 8];
      r[11'd2047 - {f, 3'b000} -: 8] = iv;
    end
    return r;
  endfunction

  localparam logic [2047:0] INV_TBL = build_inv();

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] r;
    if (INV_EN && inv) r = INV_TBL[11'd2047 - {b, 3'b000} -: 8];
    else               r = FWD_TBL[11'd2047 - {b, 3'b000} -: 8];
    return r;
  endfunction

  logic [W-1:0]    data_q   [PIPE];
  logic [PIPE-1:0] mode_q;
  logic [PIPE-1:0] vld_q;
  logic [W-1:0]    src_data [PIPE];
  logic [PIPE-1:0] src_mode;
  logic [PIPE-1:0] src_vld;
  logic [PIPE-1:0] ld;
  logic [W-1:0]    lk_in;
  logic            lk_mode;
  logic [W-1:0]    lk_data;

  // With a single stage the lookup sits in front of the only register.
  if (PIPE == 1) begin : g_lk_direct
    assign lk_in   = in_data;
    assign lk_mode = in_mode;
  end else begin : g_lk_reg
    assign lk_in   = data_q[0];
    assign lk_mode = mode_q[0];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lk_data[8*g +: 8] = sub_byte(lk_in[8*g +: 8], lk_mode);
  end

  // Stage k may load when it, or any stage after it, has room, or when the
  // output is being taken: bubbles collapse and a full pipe still streams.
  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    assign ld[k] = out_ready | ~(&vld_q[PIPE-1:k]);
    if (k == 0) begin : g_src_in
      assign src_vld[0]  = in_valid;
      assign src_mode[0] = in_mode;
      assign src_data[0] = (PIPE == 1) ? lk_data : in_data;
    end else if (k == 1) begin : g_src_lk
      assign src_vld[1]  = vld_q[0];
      assign src_mode[1] = mode_q[0];
      assign src_data[1] = lk_data;
    end else begin : g_src_rt
      assign src_vld[k]  = vld_q[k-1];
      assign src_mode[k] = mode_q[k-1];
      assign src_data[k] = data_q[k-1];
    end
  end

  // Stage registers; payload only captured with a valid beat so idle input
  // garbage never reaches the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < PIPE; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (ld[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) begin
            data_q[k] <= src_data[k];
            mode_q[k] <= src_mode[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[PIPE-1];
  assign out_data  = data_q[PIPE-1];
  assign out_mode  = mode_q[PIPE-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Directed bench for sbox_lane_pipe: three 4-lane builds (PIPE=1 forward
// only, PIPE=2 and PIPE=3 with inverse) share one input bus; each test
// observes one build's outputs.
module tb_sbox_lane_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [2:0]  ir, ov, om, bz;
  logic [31:0] od [3];

  always #5 clk = ~clk;

  sbox_lane_pipe #(.LANES(4), .PIPE(1), .INV_EN(1'b0)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_mode(om[0]),
    .out_data(od[0]), .busy(bz[0]));

  sbox_lane_pipe #(.LANES(4), .PIPE(2), .INV_EN(1'b1)) u_p2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_mode(om[1]),
    .out_data(od[1]), .busy(bz[1]));

  sbox_lane_pipe #(.LANES(4), .PIPE(3), .INV_EN(1'b1)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_mode(in_mode),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_mode(om[2]),
    .out_data(od[2]), .busy(bz[2]));

  int total = 0;
  int bad   = 0;

  logic [31:0] in_d  [8];
  logic [31:0] ex_d  [8];
  logic        in_m  [8];
  logic [31:0] got_d [8];
  logic        got_m [8];
  int          got_c [8];
  int          ngot;
  int          hold_sent;
  logic        hold_ir;
  logic [31:0] hold_od;

  // S-box of 0x00..0x07 (first row of the FIPS-197 table)
  logic [7:0] flo [8] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Eight alternating beats: even = forward, odd = inverse; lane 0 tags order.
  task automatic load_mix();
    for (int i = 0; i < 8; i++) begin
      in_m[i] = i[0];
      if (i[0] == 1'b0) begin
        in_d[i] = {8'h53, 8'h00, 8'h11, 8'(i)};
        ex_d[i] = {8'hed, 8'h63, 8'h82, flo[i]};
      end else begin
        in_d[i] = {8'hed, 8'h63, 8'h82, flo[i]};
        ex_d[i] = {8'h53, 8'h00, 8'h11, 8'(i)};
      end
    end
  endtask

  // Sends n beats from in_d/in_m into build sel; out_ready held low for the
  // first 'hold' cycles. Outputs and the cycle they were taken are recorded.
  task automatic run_stream(input int sel, input int n, input int hold);
    int cyc;
    int sent;
    cyc = 0; sent = 0; ngot = 0;
    hold_sent = -1; hold_ir = 1'b1; hold_od = '0;
    while (ngot < n && cyc < 40) begin
      out_ready = (cyc >= hold);
      in_valid  = (sent < n);
      if (sent < n) begin
        in_data = in_d[sent];
        in_mode = in_m[sent];
      end
      #1;
      if (ov[sel] && out_ready && ngot < 8) begin
        got_d[ngot] = od[sel];
        got_m[ngot] = om[sel];
        got_c[ngot] = cyc;
        ngot++;
      end
      if (in_valid && ir[sel]) sent++;
      if (cyc == hold - 1) begin
        hold_sent = sent;
        hold_ir   = ir[sel];
        hold_od   = od[sel];
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("beat_count_p%0d", sel + 1), ngot, n);
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_order(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < ngot) begin
        chk($sformatf("%s_data%0d", tag, i), got_d[i], ex_d[i]);
        chk($sformatf("%s_mode%0d", tag, i), got_m[i], in_m[i]);
      end
    end
  endtask

  initial begin
    #3;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_valid_p%0d", s + 1), ov[s], 0);
      chk($sformatf("rst_busy_p%0d", s + 1), bz[s], 0);
      chk($sformatf("rst_data_p%0d", s + 1), od[s], 0);
      chk($sformatf("rst_mode_p%0d", s + 1), om[s], 0);
    end
    #9 rst = 1'b0;
    #1 chk("rst_in_ready", ir, 3'b111);
    @(posedge clk); #1;

    // single forward beat, PIPE=2
    in_d[0] = 32'h00112233; in_m[0] = 1'b0;
    run_stream(1, 1, 0);
    chk("single_lat", got_c[0], 2);
    chk("single_data", got_d[0], 32'h638293c3);
    chk("single_mode", got_m[0], 0);
    flush();

    // inverse round trip, then 16->FF inverse and FF->16 forward
    in_d[0] = 32'h638293c3; in_m[0] = 1'b1; ex_d[0] = 32'h00112233;
    in_d[1] = 32'h16ed6300; in_m[1] = 1'b1; ex_d[1] = 32'hff530052;
    in_d[2] = 32'hff530001; in_m[2] = 1'b0; ex_d[2] = 32'h16ed637c;
    run_stream(1, 3, 0);
    chk_order("inv", 3);
    flush();

    // back-to-back alternating modes at full rate
    load_mix();
    run_stream(1, 8, 0);
    chk_order("stream", 8);
    chk("stream_lat", got_c[0], 2);
    chk("stream_rate", got_c[7] - got_c[0], 7);
    flush();

    // backpressure: pipe holds exactly 2 beats, output stable, drains in order
    load_mix();
    run_stream(1, 8, 6);
    chk("bp_accepted", hold_sent, 2);
    chk("bp_in_ready", hold_ir, 0);
    chk("bp_hold_data", hold_od, ex_d[0]);
    chk_order("bp", 8);
    flush();

    // reset with two beats in flight
    load_mix();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = in_d[0]; in_mode = in_m[0];
    @(posedge clk); #1;
    in_data = in_d[1]; in_mode = in_m[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", bz[1], 1);
    chk("pre_rst_valid", ov[1], 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[1], 0);
    chk("mid_rst_busy", bz[1], 0);
    chk("mid_rst_data", od[1], 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    in_d[0] = 32'h00000001; in_m[0] = 1'b0;
    run_stream(1, 1, 0);
    chk("post_rst_lat", got_c[0], 2);
    chk("post_rst_data", got_d[0], 32'h6363637c);
    flush();

    // forward-only PIPE=1 build ignores mode for the lookup
    in_d[0] = 32'h00ff5301; in_m[0] = 1'b1;
    run_stream(0, 1, 0);
    chk("noinv_lat", got_c[0], 1);
    chk("noinv_data", got_d[0], 32'h6316ed7c);
    chk("noinv_mode", got_m[0], 1);
    flush();

    // PIPE=3 latency and capacity
    in_d[0] = 32'h638293c3; in_m[0] = 1'b1;
    run_stream(2, 1, 0);
    chk("p3_lat", got_c[0], 3);
    chk("p3_data", got_d[0], 32'h00112233);
    flush();

    load_mix();
    run_stream(2, 5, 6);
    chk("p3_bp_accepted", hold_sent, 3);
    chk("p3_bp_in_ready", hold_ir, 0);
    chk("p3_bp_hold_data", hold_od, ex_d[0]);
    chk_order("p3_bp", 5);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
